// File: rtl/mc_control.sv
// Multi-cycle main controller for the MIPS-lite core: sequences fetch/decode/
// execute/memory/writeback, drives datapath selects and counts retired instructions.
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_op,
    output logic [1:0]       aluop,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_ORIEXEC = 4'd8,
        S_ORIWB   = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ORI   = 2'b11;

    state_t state_r;
    state_t state_nxt_s;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ORI, OP_J: op_legal = 1'b1;
            default:                                      op_legal = 1'b0;
        endcase
    endfunction

    // Next-state selection; unknown encodings and unsupported opcodes fall back to FETCH.
    always_comb begin
        state_nxt_s = S_FETCH;
        case (state_r)
            S_FETCH:   state_nxt_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt_s = S_MEMADR;
                    OP_RTYPE:     state_nxt_s = S_EXEC;
                    OP_ORI:       state_nxt_s = S_ORIEXEC;
                    OP_BEQ:       state_nxt_s = S_BRANCH;
                    OP_J:         state_nxt_s = S_JUMP;
                    default:      state_nxt_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    state_nxt_s = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_nxt_s = S_MEMWR;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_MEMRD:   state_nxt_s = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_nxt_s = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_nxt_s = S_ALUWB;
            S_ORIEXEC: state_nxt_s = S_ORIWB;
            default:   state_nxt_s = S_FETCH;
        endcase
    end

    // Moore output decode; reset forces every strobe low, including the FETCH ones.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ext_op        = 1'b1;
        aluop         = ALU_ADD;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        if (rst) begin
            ext_op = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = ~op_legal(opcode);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    aluop     = ALU_RTYPE;
                end
                S_ALUWB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_ORIEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ext_op    = 1'b0;
                    aluop     = ALU_ORI;
                end
                S_ORIWB: begin
                    reg_write  = 1'b1;
                    ext_op     = 1'b0;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    aluop         = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

    // State register and retired-instruction counter (wraps naturally).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
            instret <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (instr_done) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle main controller for the MIPS-lite core. It sequences every instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects and write strobes, and produces the 2-bit `aluop` consumed directly by `alu_control`. It also waits on a single-ported memory through a ready handshake and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `mem_ready`  in  1  memory completed the access requested this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if ALU zero (beq)
- `pc_source`  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- `iord`  out  1  memory address: 0 PC, 1 ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  load IR from memory data
- `reg_dst`  out  1  write register: 0 rt, 1 rd
- `mem_to_reg`  out  1  writeback data: 0 ALUOut, 1 MDR
- `reg_write`  out  1  register-file write enable
- `alu_src_a`  out  1  0 PC, 1 register A
- `alu_src_b`  out  2  00 register B, 01 constant 4, 10 extended imm, 11 sign-ext imm<<2
- `ext_op`  out  1  immediate extension: 0 zero, 1 sign
- `aluop`  out  2  to `alu_control`: 00 ADD, 01 SUB, 10 R_TYPE, 11 ORI
- `illegal_op`  out  1  one-cycle pulse on unsupported opcode
- `instr_done`  out  1  one-cycle pulse when an instruction retires
- `instret`  out  CNT_W  retired-instruction count

## Operation
- Supported opcodes:
  - 000000 R-type (addu/subu via funct in `alu_control`)
  - 100011 lw
  - 101011 sw
  - 000100 beq
  - 001101 ori
  - 000010 j
- The state register is 4 bits. Outputs are decoded from state (Moore), except that FETCH gates `pc_write` and `ir_write` with `mem_ready`.
- Any output not listed for a state is 0. `aluop` defaults to ADD and `ext_op` defaults to 1.
- FETCH:
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `aluop`=ADD, `pc_source`=00, `pc_write`=`ir_write`=`mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE:
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `aluop`=ADD (precomputes the branch target).
  - Next state: lw/sw go to MEMADR, R-type to EXEC, ori to ORIEXEC, beq to BRANCH, j to JUMP.
  - Any other opcode goes to FETCH with `illegal_op`=1 for that DECODE cycle. An illegal opcode does not retire.
- MEMADR:
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `ext_op`=1, `aluop`=ADD.
  - Next state: lw goes to MEMRD, sw goes to MEMWR.
- MEMRD: `iord`=1, `mem_read`=1; hold until `mem_ready`, then go to MEMWB.
- MEMWB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1; retires; go to FETCH.
- MEMWR: `iord`=1, `mem_write`=1; hold until `mem_ready`, then retire and go to FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `aluop`=R_TYPE; go to ALUWB.
- ALUWB: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1; retires; go to FETCH.
- ORIEXEC: `alu_src_a`=1, `alu_src_b`=10, `ext_op`=0, `aluop`=ORI; go to ORIWB.
- ORIWB: `reg_dst`=0, `reg_write`=1, `ext_op`=0; retires; go to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `aluop`=SUB, `pc_write_cond`=1, `pc_source`=01; retires; go to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10; retires; go to FETCH.
- Retirement:
  - `instr_done`=1 combinationally in each retiring cycle listed above.
  - `instret` increments by 1 on the following edge and wraps modulo 2^CNT_W.
- Undefined state encodings go to FETCH on the next edge.

## Timing
- Reset:
  - `rst`=1 at an edge sets state to FETCH and `instret` to 0.
  - While `rst` is high, every output is forced to 0 (`aluop`=00), including the FETCH strobes.
  - Reset mid-instruction discards that instruction and does not retire it.
- First fetch request: the first rising edge after `rst` falls.
- Minimum cycles per instruction with `mem_ready` held at 1:
  - j and beq: 3
  - R-type, ori and sw: 4
  - lw: 5
  - Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored in every other state.
- `mem_read` and `mem_write` stay asserted and stable until the accepting `mem_ready` cycle.
- `opcode` is sampled only in DECODE and MEMADR.

## Test plan
- Reset with `mem_ready`=1:
  - Hold `rst`=1 for 3 cycles: every output is 0 and `instret`=0.
  - First cycle after release: `mem_read`=1, `pc_write`=1, `ir_write`=1, `aluop`=00.
- addu with `opcode`=000000 and `mem_ready`=1:
  - States are FETCH, DECODE, EXEC, ALUWB.
  - EXEC has `aluop`=10. ALUWB has `reg_write`=1, `reg_dst`=1.
  - `instret` goes 0 to 1.
- lw with `opcode`=100011 and 2 wait cycles in MEMRD:
  - `mem_read`=1, `iord`=1 are held for 3 cycles.
  - MEMWB has `mem_to_reg`=1. Total 7 cycles.
- beq (000100) followed by ori (001101):
  - BRANCH has `aluop`=01, `pc_write_cond`=1, `pc_source`=01.
  - ORIEXEC has `aluop`=11, `ext_op`=0.
  - `instret`=2 afterwards.
- Illegal opcode 111111:
  - `illegal_op` pulses in DECODE and the next state is FETCH.
  - `instr_done` stays 0 and `instret` is unchanged.
- Assert `rst` during MEMWR with `mem_ready`=0:
  - `mem_write` drops immediately and the state returns to FETCH.
  - `instret` is 0.
